// File: rtl/ctrl_trafficlight_multi.sv
`default_nettype none
// ============================================================================
// Module   : ctrl_trafficlight_multi
// Brief    : Round-robin traffic-light controller for NUM_DIR approaches with
//            all-red clearance, tick-driven phase timers and a night flash mode.
// Revision : 1.0
// ============================================================================
module ctrl_trafficlight_multi #(
   parameter int NUM_DIR  = 3,
   parameter int CNT_W    = 8,
   parameter int T_GREEN  = 4,
   parameter int T_YELLOW = 2,
   parameter int T_ALLRED = 1,
   parameter int T_PREP   = 1,
   parameter int T_FLASH  = 2,
   localparam int DIR_W   = $clog2(NUM_DIR)
) (
   input  logic                   clk,
   input  logic                   res,
   input  logic                   tick,
   input  logic [NUM_DIR-1:0]     req,
   input  logic                   night,
   output logic [3*NUM_DIR-1:0]   rgb,
   output logic [DIR_W-1:0]       active_dir,
   output logic [NUM_DIR-1:0]     req_pending
);

   localparam logic [2:0] COL_RED    = 3'b100;
   localparam logic [2:0] COL_YELLOW = 3'b110;
   localparam logic [2:0] COL_GREEN  = 3'b010;
   localparam logic [2:0] COL_OFF    = 3'b000;

   typedef enum logic [2:0] {
      S_ALLRED = 3'd0,
      S_PREP   = 3'd1,
      S_GREEN  = 3'd2,
      S_YELLOW = 3'd3,
      S_FLASH  = 3'd4
   } state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   timer_q, timer_d;
   logic [DIR_W-1:0]   dir_q,   dir_d;
   logic [NUM_DIR-1:0] pend_q,  pend_d;
   logic               flash_q, flash_d;

   logic [NUM_DIR-1:0] w_act_mask;
   logic [NUM_DIR-1:0] w_other;
   logic [DIR_W-1:0]   w_next_dir;

   assign w_act_mask = {{(NUM_DIR-1){1'b0}}, 1'b1} << dir_q;
   assign w_other    = pend_q & ~w_act_mask;

   // First pending approach after the active one, wrapping modulo NUM_DIR.
   always_comb begin : p_rr_search
      logic [DIR_W:0] sum;
      logic           found;
      sum        = '0;
      found      = 1'b0;
      w_next_dir = dir_q;
      for (int k = 1; k < NUM_DIR; k++) begin
         sum = {1'b0, dir_q} + (DIR_W+1)'(k);
         if (sum >= (DIR_W+1)'(NUM_DIR)) begin
            sum = sum - (DIR_W+1)'(NUM_DIR);
         end
         if (!found && pend_q[sum[DIR_W-1:0]]) begin
            found      = 1'b1;
            w_next_dir = sum[DIR_W-1:0];
         end
      end
   end

   always_comb begin : p_next_state
      state_d = state_q;
      timer_d = timer_q;
      dir_d   = dir_q;
      flash_d = flash_q;
      if (tick) begin
         timer_d = timer_q + CNT_W'(1);
         case (state_q)
            S_ALLRED: begin
               if (timer_q == CNT_W'(T_ALLRED-1)) begin
                  state_d = night ? S_FLASH : S_PREP;
               end
            end
            S_PREP: begin
               if (timer_q == CNT_W'(T_PREP-1)) begin
                  state_d = S_GREEN;
               end
            end
            S_GREEN: begin
               if (timer_q == CNT_W'(T_GREEN-1)) begin
                  timer_d = timer_q;
                  if (|w_other) begin
                     state_d = S_YELLOW;
                     dir_d   = w_next_dir;
                  end else if (night) begin
                     state_d = S_YELLOW;
                  end
               end
            end
            S_YELLOW: begin
               if (timer_q == CNT_W'(T_YELLOW-1)) begin
                  state_d = S_ALLRED;
               end
            end
            S_FLASH: begin
               if (!night) begin
                  state_d = S_ALLRED;
                  flash_d = 1'b0;
               end else if (timer_q == CNT_W'(T_FLASH-1)) begin
                  flash_d = ~flash_q;
                  timer_d = '0;
               end
            end
            default: state_d = S_ALLRED;
         endcase
         if (state_d != state_q) begin
            timer_d = '0;
         end
      end

      // Request latch runs every clk; the GREEN-entry clear overrides a set.
      pend_d = pend_q | (req & ~((state_q == S_GREEN) ? w_act_mask : '0));
      if (state_d == S_GREEN && state_q != S_GREEN) begin
         pend_d = pend_d & ~w_act_mask;
      end
      if (state_q == S_FLASH || state_d == S_FLASH) begin
         pend_d = '0;
      end
   end

   always_ff @(posedge clk or posedge res) begin
      if (res) begin
         state_q <= S_ALLRED;
         timer_q <= '0;
         dir_q   <= '0;
         pend_q  <= '0;
         flash_q <= 1'b0;
      end else begin
         state_q <= state_d;
         timer_q <= timer_d;
         dir_q   <= dir_d;
         pend_q  <= pend_d;
         flash_q <= flash_d;
      end
   end

   always_comb begin : p_rgb
      logic [2:0] col;
      col = COL_RED;
      rgb = '0;
      for (int i = 0; i < NUM_DIR; i++) begin
         col = COL_RED;
         case (state_q)
            S_PREP, S_YELLOW: if (w_act_mask[i]) col = COL_YELLOW;
            S_GREEN:          if (w_act_mask[i]) col = COL_GREEN;
            S_FLASH:          col = flash_q ? COL_OFF : COL_YELLOW;
            default:          col = COL_RED;
         endcase
         rgb[3*i +: 3] = col;
      end
   end

   assign active_dir  = dir_q;
   assign req_pending = pend_q;

endmodule
`default_nettype wire

// File: tb/tb_ctrl_trafficlight_multi.sv
`default_nettype none
// ============================================================================
// Module   : tb_ctrl_trafficlight_multi
// Brief    : Directed scoreboard bench for ctrl_trafficlight_multi (3 approaches).
// Revision : 1.0
// ============================================================================
module tb_ctrl_trafficlight_multi;

   localparam logic [2:0] R = 3'b100;
   localparam logic [2:0] Y = 3'b110;
   localparam logic [2:0] G = 3'b010;
   localparam logic [2:0] O = 3'b000;

   logic       clk;
   logic       res;
   logic       tick;
   logic [2:0] req;
   logic       night;
   logic [8:0] rgb;
   logic [1:0] active_dir;
   logic [2:0] req_pending;

   ctrl_trafficlight_multi dut (
      .clk         (clk),
      .res         (res),
      .tick        (tick),
      .req         (req),
      .night       (night),
      .rgb         (rgb),
      .active_dir  (active_dir),
      .req_pending (req_pending)
   );

   typedef struct {
      int          cyc;
      logic [63:0] tag;
      logic [8:0]  rgb;
      logic [1:0]  dir;
      logic [2:0]  pend;
   } exp_t;

   exp_t exp_q[$];
   int   cyc      = 0;
   int   n_vec    = 0;
   int   n_fail   = 0;
   int   tick_div = 1;
   int   tick_ph  = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: compares queued expectations at the falling edge of their cycle.
   always @(negedge clk) begin
      while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
         exp_t e;
         e = exp_q.pop_front();
         n_vec++;
         if (e.cyc != cyc || rgb !== e.rgb || active_dir !== e.dir || req_pending !== e.pend) begin
            n_fail++;
            $display("FAIL %0s cyc=%0d/%0d got rgb=%b dir=%0d pend=%b want rgb=%b dir=%0d pend=%b",
                     e.tag, cyc, e.cyc, rgb, active_dir, req_pending, e.rgb, e.dir, e.pend);
         end
      end
   end

   task automatic chk(input logic [63:0] tag, input logic [2:0] c2, input logic [2:0] c1,
                      input logic [2:0] c0, input logic [1:0] dir, input logic [2:0] pend);
      exp_t e;
      e.cyc  = cyc;
      e.tag  = tag;
      e.rgb  = {c2, c1, c0};
      e.dir  = dir;
      e.pend = pend;
      exp_q.push_back(e);
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
         if (tick_div != 1) begin
            tick_ph++;
            tick = (tick_ph % tick_div == 0);
         end
      end
   endtask

   task automatic do_reset();
      res = 1'b1;
      chk("rst0", R, R, R, 2'd0, 3'b000);
      step(1);
      chk("rst1", R, R, R, 2'd0, 3'b000);
      step(2);
      res = 1'b0;
   endtask

   task automatic powerup();
      step(1);  chk("pu_prep", R, R, Y, 2'd0, 3'b000);
      step(1);  chk("pu_grn",  R, R, G, 2'd0, 3'b000);
      step(20); chk("pu_hold", R, R, G, 2'd0, 3'b000);
   endtask

   initial begin
      #20000;
      $display("FAIL watchdog cyc=%0d got no finish want finish", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      res = 1'b1; tick = 1'b1; req = 3'b000; night = 1'b0;
      step(1);
      // 1: reset and power-up
      do_reset();
      powerup();

      // 2: single request from dir2
      req = 3'b100;
      step(1); chk("s2_latch", R, R, G, 2'd0, 3'b100);
      req = 3'b000;
      step(1); chk("s2_yel0",  Y, R, R, 2'd2, 3'b100);
      step(1); chk("s2_yel1",  Y, R, R, 2'd2, 3'b100);
      step(1); chk("s2_allr",  R, R, R, 2'd2, 3'b100);
      step(1); chk("s2_prep",  Y, R, R, 2'd2, 3'b100);
      step(1); chk("s2_grn",   G, R, R, 2'd2, 3'b000);

      // 3: round robin, reach dir1 first
      step(5);
      req = 3'b010;
      step(1); chk("s3_l1",    G, R, R, 2'd2, 3'b010);
      req = 3'b000;
      step(5); chk("s3_g1",    R, G, R, 2'd1, 3'b000);
      req = 3'b111;
      step(1); chk("s3_l02",   R, G, R, 2'd1, 3'b101);
      req = 3'b000;
      step(3); chk("s3_y2",    Y, R, R, 2'd2, 3'b101);
      step(4); chk("s3_g2",    G, R, R, 2'd2, 3'b001);
      step(8); chk("s3_g0",    R, R, G, 2'd0, 3'b000);

      // 4: minimum green with tick every 4th cycle
      tick_div = 4; tick_ph = 0; tick = 1'b0;
      req = 3'b010;
      step(1);  chk("s4_latch", R, R, G, 2'd0, 3'b010);
      req = 3'b000;
      step(15); chk("s4_early", R, R, G, 2'd0, 3'b010);
      step(1);  chk("s4_yel",   R, Y, R, 2'd1, 3'b010);
      tick_div = 1; tick = 1'b1;
      step(4);  chk("s4_g1",    R, G, R, 2'd1, 3'b000);

      // 5: night mode
      req = 3'b001;
      step(1); chk("s5_latch", R, G, R, 2'd1, 3'b001);
      req = 3'b000;
      step(7); chk("s5_g0",    R, R, G, 2'd0, 3'b000);
      night = 1'b1;
      step(4); chk("s5_yel",   R, R, Y, 2'd0, 3'b000);
      step(2); chk("s5_allr",  R, R, R, 2'd0, 3'b000);
      step(1); chk("s5_fy0",   Y, Y, Y, 2'd0, 3'b000);
      req = 3'b111;
      step(1); chk("s5_fy1",   Y, Y, Y, 2'd0, 3'b000);
      step(1); chk("s5_fo0",   O, O, O, 2'd0, 3'b000);
      step(1); chk("s5_fo1",   O, O, O, 2'd0, 3'b000);
      step(1); chk("s5_fy2",   Y, Y, Y, 2'd0, 3'b000);
      night = 1'b0; req = 3'b000;
      step(1); chk("s5_exit",  R, R, R, 2'd0, 3'b000);
      step(1); chk("s5_prep",  R, R, Y, 2'd0, 3'b000);
      step(1); chk("s5_grn",   R, R, G, 2'd0, 3'b000);

      // 6: asynchronous reset during YELLOW
      req = 3'b010;
      step(1); chk("s6_latch", R, R, G, 2'd0, 3'b010);
      req = 3'b000;
      step(3); chk("s6_yel",   R, Y, R, 2'd1, 3'b010);
      step(1);
      #2;
      do_reset();
      powerup();

      step(2);
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL drain got %0d pending checks want 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
